// File: rtl/regfile_nxm.sv
// regfile_nxm
//   DEPTH x DATA_WIDTH register file with one write port, two independent
//   read ports (A/B) and a self-timed clear sweep. The sweep zeroes every
//   entry, one per clock. It runs after reset release and on a CLR request.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | normal operation: writes accepted, reads return memory
//   CLEAR  | sweep in progress: entry cnt zeroed each edge, BUSY = 1
//
// Ports
//   UserCLK    : clock for all sequential logic
//   RESETn     : asynchronous active-low reset (release synchronous to UserCLK)
//   D          : write data
//   W_ADR      : write address
//   W_en       : write enable (ignored while BUSY or when CLR is high)
//   CLR        : request a clear sweep (ignored while a sweep is running)
//   A_ADR      : read address, port A
//   B_ADR      : read address, port B
//   AD         : read data, port A (0 while BUSY)
//   BD         : read data, port B (0 while BUSY)
//   BUSY       : high while the clear sweep is in progress
//   ConfigBits : [0] registered A, [1] registered B, [2] write-through bypass
module regfile_nxm #(
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 5,
  parameter int NoConfigBits = 3
) (
  input  logic                    UserCLK,
  input  logic                    RESETn,
  input  logic [DATA_WIDTH-1:0]   D,
  input  logic [ADDR_WIDTH-1:0]   W_ADR,
  input  logic                    W_en,
  input  logic                    CLR,
  input  logic [ADDR_WIDTH-1:0]   A_ADR,
  input  logic [ADDR_WIDTH-1:0]   B_ADR,
  output logic [DATA_WIDTH-1:0]   AD,
  output logic [DATA_WIDTH-1:0]   BD,
  output logic                    BUSY,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   ra_q, rb_q;
  logic [DATA_WIDTH-1:0]   rd_a, rd_b;
  logic [DATA_WIDTH-1:0]   a_next, b_next;
  logic                    busy;
  logic                    wr_go;
  logic                    clr_go;
  logic                    bypass_ok;

  assign busy = (state_q == S_CLEAR);
  assign BUSY = busy;

  // RESETn forces CLEAR asynchronously; gating the sweep write with RESETn
  // keeps the memory untouched while reset is held.
  assign clr_go = busy && RESETn;
  assign wr_go  = (state_q == S_IDLE) && W_en && !CLR;

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (CLR) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        // CLR is ignored here; the counter wraps to 0 naturally at CNT_LAST.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage has no reset; it is zeroed by the sweep instead.
  always_ff @(posedge UserCLK) begin
    if (clr_go) begin
      mem[cnt_q] <= '0;
    end else if (wr_go) begin
      mem[W_ADR] <= D;
    end
  end

  // The bypass is qualified by the same conditions as a real write, so it
  // only shows D when that D is actually about to land.
  assign bypass_ok = ConfigBits[2] && wr_go;

  assign rd_a = (bypass_ok && (W_ADR == A_ADR)) ? D : mem[A_ADR];
  assign rd_b = (bypass_ok && (W_ADR == B_ADR)) ? D : mem[B_ADR];

  assign a_next = busy ? '0 : rd_a;
  assign b_next = busy ? '0 : rd_b;

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      ra_q <= a_next;
      rb_q <= b_next;
    end
  end

  assign AD = ConfigBits[0] ? (busy ? '0 : ra_q) : a_next;
  assign BD = ConfigBits[1] ? (busy ? '0 : rb_q) : b_next;

endmodule

// File: tb/tb_regfile_nxm.sv
module tb_regfile_nxm;

  logic       UserCLK;
  logic       RESETn;
  logic [3:0] D;
  logic [4:0] W_ADR;
  logic       W_en;
  logic       CLR;
  logic [4:0] A_ADR;
  logic [4:0] B_ADR;
  logic [3:0] AD;
  logic [3:0] BD;
  logic       BUSY;
  logic [2:0] ConfigBits;

  regfile_nxm #(
    .DATA_WIDTH  (4),
    .ADDR_WIDTH  (5),
    .NoConfigBits(3)
  ) dut (
    .UserCLK   (UserCLK),
    .RESETn    (RESETn),
    .D         (D),
    .W_ADR     (W_ADR),
    .W_en      (W_en),
    .CLR       (CLR),
    .A_ADR     (A_ADR),
    .B_ADR     (B_ADR),
    .AD        (AD),
    .BD        (BD),
    .BUSY      (BUSY),
    .ConfigBits(ConfigBits)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  typedef struct {
    string      name;
    bit         ca;
    logic [3:0] a;
    bit         cb;
    logic [3:0] b;
    bit         cy;
    logic       y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Expectations describe the outputs seen in the half-cycle after the
  // inputs were driven; the monitor consumes them on the falling edge.
  task automatic expect_out(input string name,
                            input bit ca, input logic [3:0] a,
                            input bit cb, input logic [3:0] b,
                            input bit cy, input logic y);
    exp_t e;
    e.name = name; e.ca = ca; e.a = a; e.cb = cb; e.b = b; e.cy = cy; e.y = y;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic past_check();
    @(negedge UserCLK);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge UserCLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.ca) begin
          checks++;
          if (AD !== e.a) begin
            errors++;
            $display("FAIL %s AD got %h want %h", e.name, AD, e.a);
          end
        end
        if (e.cb) begin
          checks++;
          if (BD !== e.b) begin
            errors++;
            $display("FAIL %s BD got %h want %h", e.name, BD, e.b);
          end
        end
        if (e.cy) begin
          checks++;
          if (BUSY !== e.y) begin
            errors++;
            $display("FAIL %s BUSY got %b want %b", e.name, BUSY, e.y);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    RESETn = 1'b0; ConfigBits = 3'b000;
    D = 4'h5; W_ADR = 5'd0; W_en = 1'b1; CLR = 1'b0;
    A_ADR = 5'd0; B_ADR = 5'd1;

    // Reset is visible before any clock edge.
    #1;
    expect_out("reset", 1, 4'h0, 1, 4'h0, 1, 1'b1);
    tick();
    tick();

    // Release with W_en high: 32-edge sweep, outputs held at 0.
    RESETn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      expect_out("rel_sweep", 1, 4'h0, 1, 4'h0, 1, 1'b1);
      tick();
    end
    W_en = 1'b0;
    A_ADR = 5'd0;
    expect_out("rel_done", 1, 4'h0, 0, 4'h0, 1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      A_ADR = 5'(i); B_ADR = 5'(31 - i);
      expect_out("rel_zero", 1, 4'h0, 1, 4'h0, 0, 1'b0);
      tick();
    end

    // Combinational reads, old data before the write edge.
    ConfigBits = 3'b000;
    W_en = 1'b1; W_ADR = 5'd5; D = 4'hA;
    tick();
    W_en = 1'b0; A_ADR = 5'd5; B_ADR = 5'd5;
    expect_out("comb_ab", 1, 4'hA, 1, 4'hA, 0, 1'b0);
    tick();
    W_en = 1'b1; W_ADR = 5'd5; D = 4'h3;
    expect_out("comb_old", 1, 4'hA, 0, 4'h0, 0, 1'b0);
    tick();
    W_en = 1'b0;
    expect_out("comb_new", 1, 4'h3, 1, 4'h3, 0, 1'b0);
    tick();

    // Registered reads: one edge of latency on both ports.
    ConfigBits = 3'b011;
    W_en = 1'b1; W_ADR = 5'd7; D = 4'h6; A_ADR = 5'd0; B_ADR = 5'd0;
    tick();
    W_en = 1'b0; A_ADR = 5'd7; B_ADR = 5'd7;
    expect_out("reg_before", 1, 4'h0, 1, 4'h0, 0, 1'b0);
    tick();
    expect_out("reg_after", 1, 4'h6, 1, 4'h6, 0, 1'b0);
    tick();

    // Bypass: write-through on the matching port only.
    ConfigBits = 3'b100;
    W_en = 1'b1; W_ADR = 5'd9; D = 4'h1;
    tick();
    W_en = 1'b1; W_ADR = 5'd9; D = 4'hC; A_ADR = 5'd9; B_ADR = 5'd8;
    expect_out("bypass", 1, 4'hC, 1, 4'h0, 0, 1'b0);
    tick();
    W_en = 1'b0;
    expect_out("bypass_landed", 1, 4'hC, 0, 4'h0, 0, 1'b0);
    tick();
    // CLR suppresses the bypass; deassert before the edge.
    W_en = 1'b1; W_ADR = 5'd9; D = 4'h2; CLR = 1'b1;
    expect_out("bypass_clr", 1, 4'hC, 0, 4'h0, 0, 1'b0);
    past_check();
    W_en = 1'b0; CLR = 1'b0;
    tick();

    // Fill with F, then CLR together with a write; a second CLR mid-sweep.
    ConfigBits = 3'b000;
    for (int i = 0; i < 32; i++) begin
      W_en = 1'b1; W_ADR = 5'(i); D = 4'hF;
      tick();
    end
    W_en = 1'b0; A_ADR = 5'd3; B_ADR = 5'd20;
    expect_out("fill", 1, 4'hF, 1, 4'hF, 1, 1'b0);
    tick();
    CLR = 1'b1; W_en = 1'b1; W_ADR = 5'd3; D = 4'h5;
    tick();
    CLR = 1'b0; W_en = 1'b0;
    for (int c = 0; c < 32; c++) begin
      CLR = (c == 10);
      expect_out("clr_sweep", 1, 4'h0, 1, 4'h0, 1, 1'b1);
      tick();
    end
    CLR = 1'b0;
    expect_out("clr_done", 1, 4'h0, 1, 4'h0, 1, 1'b0);
    tick();
    A_ADR = 5'd31; B_ADR = 5'd0;
    expect_out("clr_ends", 1, 4'h0, 1, 4'h0, 0, 1'b0);
    tick();

    // Reset mid-sweep at CNT = 20 with registered outputs.
    ConfigBits = 3'b011;
    W_en = 1'b1; W_ADR = 5'd4; D = 4'h9;
    tick();
    W_en = 1'b0; A_ADR = 5'd4; B_ADR = 5'd4;
    tick();
    expect_out("pre_rst", 1, 4'h9, 1, 4'h9, 1, 1'b0);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    RESETn = 1'b0;
    expect_out("mid_rst", 1, 4'h0, 1, 4'h0, 1, 1'b1);
    tick();
    RESETn = 1'b1;
    for (int c = 0; c < 32; c++) begin
      expect_out("rst_sweep", 1, 4'h0, 1, 4'h0, 1, 1'b1);
      tick();
    end
    expect_out("rst_done", 0, 4'h0, 0, 4'h0, 1, 1'b0);
    tick();
    expect_out("rst_zero", 1, 4'h0, 1, 4'h0, 1, 1'b0);
    tick();

    stim_done = 1'b1;
  end

  initial begin : finisher
    wait (stim_done);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge UserCLK);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_nxm.md
REGFILE_NXM -- requirements
Module: regfile_nxm

Interface
REQ-001 SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_WIDTH, default 4: bits per entry and per port; legal range 1..32.
REQ-003 Parameter ADDR_WIDTH, default 5: address bits; DEPTH = 2**ADDR_WIDTH entries; legal range 1..8.
REQ-004 Parameter NoConfigBits, default 3: configuration bit count, fixed at 3.
REQ-005 Port UserCLK, input, 1: clock for all sequential logic; external shared port.
REQ-006 Port RESETn, input, 1: asynchronous active-low reset.
REQ-007 Port D, input, DATA_WIDTH: write data.
REQ-008 Port W_ADR, input, ADDR_WIDTH: write address.
REQ-009 Port W_en, input, 1: write enable.
REQ-010 Port CLR, input, 1: request to clear all entries.
REQ-011 Port A_ADR / B_ADR, input, ADDR_WIDTH each: read addresses for ports A / B.
REQ-012 Port AD / BD, output, DATA_WIDTH each: read data for ports A / B.
REQ-013 Port BUSY, output, 1: high while a clear sweep is in progress.
REQ-014 Port ConfigBits, input, NoConfigBits: global configuration, listed last. Bit 0 selects registered A. Bit 1 selects registered B. Bit 2 enables write-through bypass.

Function
REQ-015 Storage SHALL be DEPTH x DATA_WIDTH. It has one write port and two independent read ports.
REQ-016 FSM SHALL have two states, IDLE and CLEAR. BUSY = 1 exactly when the state is CLEAR.
REQ-017 In CLEAR, each rising edge SHALL write zero to entry CNT and then increment CNT (width ADDR_WIDTH). At CNT = DEPTH-1 the state moves to IDLE and CNT wraps to 0.
REQ-018 A clear sweep SHALL last exactly DEPTH cycles. BUSY falls after the DEPTH-th edge.
REQ-019 In IDLE, CLR = 1 at a rising edge SHALL move the state to CLEAR with CNT = 0. The clear of entry 0 happens on the following edge.
REQ-020 CLR asserted while in CLEAR SHALL be ignored: no restart and no extension of the sweep.
REQ-021 In IDLE, with W_en = 1 and CLR = 0, D SHALL be written to entry W_ADR at the rising edge.
REQ-022 W_en SHALL be ignored while BUSY = 1, and also in any IDLE cycle where CLR = 1 (CLR wins).
REQ-023 The combinational read of port A SHALL be mem[A_ADR]. Exception: if ConfigBits[2] = 1, BUSY = 0, CLR = 0, W_en = 1 and W_ADR = A_ADR, it SHALL be D (bypass). Port B follows the same rule with B_ADR.
REQ-024 Registered mode (ConfigBits[n] = 1): the port output SHALL be a register. It loads the combinational read on every edge, giving 1-cycle latency. Combinational mode gives 0-cycle latency.
REQ-025 While BUSY = 1, AD and BD SHALL be 0 in both modes, and the output registers SHALL load 0.
REQ-026 With bypass disabled, a read of the address being written SHALL return the old data combinationally. In registered mode it returns the new data one edge after the write.
REQ-027 Simultaneous reads of the same address on A and B SHALL return identical data.
REQ-028 ConfigBits SHALL be treated as static. Behaviour while ConfigBits changes is undefined.

Reset
REQ-029 RESETn = 0 SHALL immediately, without waiting for a clock edge: set the state to CLEAR, set CNT to 0, set BUSY = 1, clear both output registers, and force AD = BD = 0.
REQ-030 Memory contents SHALL NOT be reset asynchronously. They are zeroed by the sweep that starts on the first edge after RESETn rises.
REQ-031 Reset asserted mid-sweep or mid-write SHALL abort the operation and restart the full sweep from entry 0 after release.
REQ-032 RESETn release SHALL be synchronous to UserCLK; synchronizing it is the integrator's responsibility.

Verification (DATA_WIDTH=4, ADDR_WIDTH=5)
REQ-033 Reset release, W_en held high -> BUSY = 1 for exactly 32 edges, AD = BD = 0 throughout, then all 32 entries read 0 and no write has landed.
REQ-034 ConfigBits = 000: write 4'hA to 5, then A_ADR = B_ADR = 5 -> AD = BD = 4'hA in the same cycle. Write 4'h3 to 5 with A_ADR = 5 -> AD = 4'hA before the edge and 4'h3 after.
REQ-035 ConfigBits = 011: set A_ADR = 7 holding 4'h6 -> AD = 4'h6 one edge later and not before; BD behaves identically.
REQ-036 ConfigBits = 100: W_en = 1, W_ADR = A_ADR = 9, D = 4'hC over old value 4'h1 -> AD = 4'hC before the edge. B_ADR = 8 -> BD unaffected.
REQ-037 Fill entries with 4'hF, pulse CLR with W_en = 1 to 3 in the same cycle, pulse CLR again at sweep cycle 10 -> sweep lasts 32 cycles, entry 3 reads 0, no restart.
REQ-038 Drop RESETn mid-sweep at CNT = 20 -> BUSY stays 1 and AD = 0 immediately; after release the sweep restarts at entry 0 and lasts 32 cycles.
